// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: runs 1..LAYERS passes of the systolic array per input
// vector. Each pass is FEED (ROW), DRAIN (ROW+COL-1), BIAS (1), and a CLEAR
// (1) between passes. The final bias-added vector is held until the consumer
// takes it. All outputs come straight from registers.
module nn_layer_sequencer #(
  parameter int LAYERS = 4,
  parameter int DEP    = 8,
  parameter int COL    = 2,
  parameter int ROW    = 2,
  parameter int W      = 16,
  parameter int B      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(LAYERS+1)-1:0]   num_layers,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DEP*COL-1:0]            in_data,
  output logic [DEP*COL-1:0]            x_data,
  input  logic [DEP*COL-1:0]            res_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DEP*COL-1:0]            out_data,
  output logic                          sys_rst,
  output logic                          feed_en,
  output logic                          bias_en,
  output logic                          input_layer,
  output logic                          output_layer,
  output logic [W-1:0]                  w_addr,
  output logic [B-1:0]                  b_addr,
  output logic [$clog2(LAYERS+1)-1:0]   layer_idx
);

  localparam int LW        = $clog2(LAYERS + 1);
  localparam int DRAIN_CYC = ROW + COL - 1;
  // Step counter covers the longer of FEED and DRAIN.
  localparam int CW        = $clog2(ROW + COL);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_BIAS  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  state_t               state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [LW-1:0]        layers_r, layers_s;
  logic [LW-1:0]        layer_idx_r, layer_idx_s;
  logic [W-1:0]         w_addr_r, w_addr_s;
  logic [B-1:0]         b_addr_r, b_addr_s;
  logic [DEP*COL-1:0]   x_data_r, x_data_s;
  logic [DEP*COL-1:0]   out_data_r, out_data_s;
  logic                 in_ready_r, in_ready_s;
  logic                 out_valid_r, out_valid_s;
  logic                 sys_rst_r, sys_rst_s;
  logic                 feed_en_r, feed_en_s;
  logic                 bias_en_r, bias_en_s;
  logic                 input_layer_r, input_layer_s;
  logic                 output_layer_r, output_layer_s;
  logic                 last_pass_s;

  // A request of 0 layers still runs one pass; oversize requests saturate.
  function automatic logic [LW-1:0] clamp_layers(input logic [LW-1:0] n);
    logic [LW-1:0] r;
    if (n == LW'(0)) begin
      r = LW'(1);
    end else if (n > LW'(LAYERS)) begin
      r = LW'(LAYERS);
    end else begin
      r = n;
    end
    return r;
  endfunction

  assign last_pass_s = (layer_idx_r == (layers_r - LW'(1)));

  // Next-state, datapath-register and next-output decode.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    layers_s    = layers_r;
    layer_idx_s = layer_idx_r;
    w_addr_s    = w_addr_r;
    b_addr_s    = b_addr_r;
    x_data_s    = x_data_r;
    out_data_s  = out_data_r;

    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          x_data_s    = in_data;
          layers_s    = clamp_layers(num_layers);
          layer_idx_s = LW'(0);
          w_addr_s    = W'(0);
          b_addr_s    = B'(0);
          cnt_s       = CW'(0);
          state_s     = ST_FEED;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FEED: begin
        if (cnt_r == CW'(ROW - 1)) begin
          // Address stays on the last row through DRAIN.
          cnt_s   = CW'(0);
          state_s = ST_DRAIN;
        end else begin
          cnt_s    = cnt_r + CW'(1);
          w_addr_s = w_addr_r + W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_r == CW'(DRAIN_CYC - 1)) begin
          cnt_s   = CW'(0);
          state_s = ST_BIAS;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_BIAS: begin
        b_addr_s = b_addr_r + B'(1);
        if (last_pass_s) begin
          out_data_s = res_data;
          state_s    = ST_OUT;
        end else begin
          layer_idx_s = layer_idx_r + LW'(1);
          state_s     = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // Next pass continues the weight stream where the last one stopped.
        w_addr_s = w_addr_r + W'(1);
        cnt_s    = CW'(0);
        state_s  = ST_FEED;
      end
      ST_OUT: begin
        if (out_ready) begin
          w_addr_s    = W'(0);
          b_addr_s    = B'(0);
          layer_idx_s = LW'(0);
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    in_ready_s     = (state_s == ST_IDLE);
    out_valid_s    = (state_s == ST_OUT);
    sys_rst_s      = (state_s == ST_IDLE) || (state_s == ST_CLEAR);
    feed_en_s      = (state_s == ST_FEED) || (state_s == ST_DRAIN);
    bias_en_s      = (state_s == ST_BIAS);
    input_layer_s  = feed_en_s && (layer_idx_s == LW'(0));
    output_layer_s = (feed_en_s || bias_en_s) && (layer_idx_s == (layers_s - LW'(1)));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= CW'(0);
      layers_r       <= LW'(1);
      layer_idx_r    <= LW'(0);
      w_addr_r       <= W'(0);
      b_addr_r       <= B'(0);
      x_data_r       <= '0;
      out_data_r     <= '0;
      in_ready_r     <= 1'b1;
      out_valid_r    <= 1'b0;
      sys_rst_r      <= 1'b1;
      feed_en_r      <= 1'b0;
      bias_en_r      <= 1'b0;
      input_layer_r  <= 1'b0;
      output_layer_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      layers_r       <= layers_s;
      layer_idx_r    <= layer_idx_s;
      w_addr_r       <= w_addr_s;
      b_addr_r       <= b_addr_s;
      x_data_r       <= x_data_s;
      out_data_r     <= out_data_s;
      in_ready_r     <= in_ready_s;
      out_valid_r    <= out_valid_s;
      sys_rst_r      <= sys_rst_s;
      feed_en_r      <= feed_en_s;
      bias_en_r      <= bias_en_s;
      input_layer_r  <= input_layer_s;
      output_layer_r <= output_layer_s;
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_data     = out_data_r;
  assign x_data       = x_data_r;
  assign sys_rst      = sys_rst_r;
  assign feed_en      = feed_en_r;
  assign bias_en      = bias_en_r;
  assign input_layer  = input_layer_r;
  assign output_layer = output_layer_r;
  assign w_addr       = w_addr_r;
  assign b_addr       = b_addr_r;
  assign layer_idx    = layer_idx_r;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: ROW=COL=2 main instance plus a
// ROW=3, W=3 instance for weight-address wrap.
module tb_nn_layer_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance signals (ROW=COL=2, DEP=8, W=B=16, LAYERS=4)
  logic [2:0]  num_layers;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, x_data, res_data, out_data;
  logic        sys_rst, feed_en, bias_en, input_layer, output_layer;
  logic [15:0] w_addr, b_addr;
  logic [2:0]  layer_idx;
  logic [6:0]  ctrl;
  assign ctrl = {in_ready, out_valid, sys_rst, feed_en, bias_en, input_layer, output_layer};

  // Wrap instance signals (ROW=3, COL=2, W=3)
  logic [2:0]  num_layers2;
  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [15:0] in_data2, x_data2, res_data2, out_data2;
  logic        sys_rst2, feed_en2, bias_en2, input_layer2, output_layer2;
  logic [2:0]  w_addr2;
  logic [15:0] b_addr2;
  logic [2:0]  layer_idx2;

  int total = 0;
  int bad   = 0;

  nn_layer_sequencer #(.LAYERS(4), .DEP(8), .COL(2), .ROW(2), .W(16), .B(16)) dut (
    .clk(clk), .rst(rst), .num_layers(num_layers), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .x_data(x_data), .res_data(res_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sys_rst(sys_rst), .feed_en(feed_en),
    .bias_en(bias_en), .input_layer(input_layer), .output_layer(output_layer),
    .w_addr(w_addr), .b_addr(b_addr), .layer_idx(layer_idx)
  );

  nn_layer_sequencer #(.LAYERS(4), .DEP(8), .COL(2), .ROW(3), .W(3), .B(16)) dut2 (
    .clk(clk), .rst(rst), .num_layers(num_layers2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .x_data(x_data2), .res_data(res_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_data(out_data2), .sys_rst(sys_rst2), .feed_en(feed_en2),
    .bias_en(bias_en2), .input_layer(input_layer2), .output_layer(output_layer2),
    .w_addr(w_addr2), .b_addr(b_addr2), .layer_idx(layer_idx2)
  );

  // Per-cycle datapath result; distinct each cycle so capture timing is visible.
  function automatic logic [15:0] res_pat(input int c);
    return 16'hA500 ^ 16'(c);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (ctrl !== 7'b1010000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 7'b1010000);
    end
    total++;
    if ({w_addr, b_addr, layer_idx} !== 35'd0) begin
      bad++; $display("FAIL reset_addr got w=%h b=%h l=%0d exp 0", w_addr, b_addr, layer_idx);
    end
    total++;
    if ({out_data, x_data} !== 32'd0) begin
      bad++; $display("FAIL reset_data got out=%h x=%h exp 0", out_data, x_data);
    end
    rst = 1'b0;
  endtask

  // One inference of eff passes (ROW=COL=2 -> 7 cycles per pass), checked every cycle.
  task automatic test_layers(input string name, input logic [2:0] nl, input int eff,
                             input logic [15:0] data);
    logic [6:0] exp_c, msk;
    int pass, p, last;
    last = 7 * eff;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready_before got=%b exp=1", name, in_ready);
    end
    in_valid   = 1'b1;
    in_data    = data;
    num_layers = nl;
    out_ready  = 1'b1;
    @(posedge clk);
    #1 in_data = ~data;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      pass = (c - 1) / 7;
      p    = (c - 1) % 7;
      if (c == last) begin
        exp_c = 7'b0100000; msk = 7'b1101100;
      end else if (p < 2) begin
        exp_c = {3'b000, 1'b1, 1'b0, (pass == 0), (pass == eff - 1)}; msk = 7'b1111111;
      end else if (p < 5) begin
        exp_c = {3'b000, 1'b1, 1'b0, 1'b0, (pass == eff - 1)}; msk = 7'b1111101;
      end else if (p == 5) begin
        exp_c = {3'b000, 1'b0, 1'b1, 1'b0, (pass == eff - 1)}; msk = 7'b1111101;
      end else begin
        exp_c = 7'b0010000; msk = 7'b1111110;
      end
      total++;
      if ((ctrl & msk) !== (exp_c & msk)) begin
        bad++; $display("FAIL %s ctrl cyc=%0d got=%b exp=%b mask=%b", name, c, ctrl, exp_c, msk);
      end
      if (c != last && p < 5) begin
        total++;
        if (w_addr !== 16'(pass * 2 + ((p < 2) ? p : 1))) begin
          bad++; $display("FAIL %s w_addr cyc=%0d got=%0d exp=%0d", name, c, w_addr,
                          pass * 2 + ((p < 2) ? p : 1));
        end
      end
      if (c != last && p == 5) begin
        total++;
        if (b_addr !== 16'(pass)) begin
          bad++; $display("FAIL %s b_addr cyc=%0d got=%0d exp=%0d", name, c, b_addr, pass);
        end
      end
      if (c != last && p <= 5) begin
        total++;
        if (layer_idx !== 3'(pass)) begin
          bad++; $display("FAIL %s layer_idx cyc=%0d got=%0d exp=%0d", name, c, layer_idx, pass);
        end
      end
      if (c == last) begin
        total++;
        if (out_data !== res_pat(last - 1)) begin
          bad++; $display("FAIL %s out_data got=%h exp=%h", name, out_data, res_pat(last - 1));
        end
        total++;
        if (x_data !== data) begin
          bad++; $display("FAIL %s x_data got=%h exp=%h", name, x_data, data);
        end
        in_valid = 1'b0;
      end
      res_data = res_pat(c);
    end
    @(negedge clk);
    total++;
    if (ctrl !== 7'b1010000 || w_addr !== 16'd0 || b_addr !== 16'd0) begin
      bad++; $display("FAIL %s idle_after got ctrl=%b w=%0d b=%0d exp ctrl=1010000 w=0 b=0",
                      name, ctrl, w_addr, b_addr);
    end
  endtask

  task automatic test_backpressure();
    in_valid   = 1'b1;
    in_data    = 16'h0403;
    num_layers = 3'd1;
    out_ready  = 1'b0;
    @(posedge clk);
    #1 in_data = 16'hFFFF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 6) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++; $display("FAIL bp early_valid got=%b exp=0", out_valid);
        end
      end
      res_data = res_pat(c);
    end
    for (int c = 7; c <= 16; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== res_pat(6) ||
          x_data !== 16'h0403 || w_addr !== 16'd1 || b_addr !== 16'd1) begin
        bad++;
        $display("FAIL bp hold cyc=%0d got v=%b r=%b out=%h x=%h w=%0d b=%0d exp v=1 r=0 out=%h x=0403 w=1 b=1",
                 c, out_valid, in_ready, out_data, x_data, w_addr, b_addr, res_pat(6));
      end
      res_data = res_pat(c);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    total++;
    if (ctrl !== 7'b1010000 || w_addr !== 16'd0 || b_addr !== 16'd0) begin
      bad++; $display("FAIL bp release got ctrl=%b w=%0d b=%0d exp ctrl=1010000 w=0 b=0",
                      ctrl, w_addr, b_addr);
    end
  endtask

  task automatic test_reset_mid();
    in_valid   = 1'b1;
    in_data    = 16'h7788;
    num_layers = 3'd3;
    out_ready  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      res_data = res_pat(c);
    end
    // Cycle 10 is the first DRAIN cycle of pass 1.
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ctrl !== 7'b1010000 || {w_addr, b_addr, layer_idx} !== 35'd0 ||
        out_data !== 16'd0 || x_data !== 16'd0) begin
      bad++; $display("FAIL rst_mid got ctrl=%b w=%0d b=%0d l=%0d out=%h x=%h exp 1010000/0",
                      ctrl, w_addr, b_addr, layer_idx, out_data, x_data);
    end
    rst = 1'b0;
  endtask

  // ROW=3, W=3, L=3: 9 cycles per pass, weight address 0..7 then wraps to 0.
  task automatic test_wrap();
    int pass, p;
    in_valid2   = 1'b1;
    in_data2    = 16'h0A0B;
    num_layers2 = 3'd3;
    out_ready2  = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      pass = (c - 1) / 9;
      p    = (c - 1) % 9;
      total++;
      if ($isunknown({w_addr2, b_addr2, layer_idx2, out_valid2, in_ready2, feed_en2, bias_en2,
                      sys_rst2, input_layer2, output_layer2, x_data2, out_data2})) begin
        bad++; $display("FAIL wrap unknown cyc=%0d w=%b", c, w_addr2);
      end
      if (p < 3) begin
        total++;
        if (feed_en2 !== 1'b1 || w_addr2 !== 3'((pass * 3 + p) % 8)) begin
          bad++; $display("FAIL wrap w_addr cyc=%0d got=%0d fe=%b exp=%0d fe=1", c, w_addr2,
                          feed_en2, (pass * 3 + p) % 8);
        end
      end
      if (c >= 26) begin
        total++;
        if (out_valid2 !== (c == 27)) begin
          bad++; $display("FAIL wrap out_valid cyc=%0d got=%b exp=%b", c, out_valid2, (c == 27));
        end
      end
    end
    @(negedge clk);
    total++;
    if (in_ready2 !== 1'b1 || out_data2 !== 16'h1234) begin
      bad++; $display("FAIL wrap done got r=%b out=%h exp r=1 out=1234", in_ready2, out_data2);
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = 16'd0;
    num_layers  = 3'd0;
    out_ready   = 1'b1;
    res_data    = 16'd0;
    in_valid2   = 1'b0;
    in_data2    = 16'd0;
    num_layers2 = 3'd0;
    out_ready2  = 1'b1;
    res_data2   = 16'h1234;
    test_reset();
    test_layers("l1", 3'd1, 1, 16'h0201);
    test_layers("l3", 3'd3, 3, 16'h1122);
    test_layers("n0", 3'd0, 1, 16'h3344);
    test_layers("n7", 3'd7, 4, 16'h5566);
    test_backpressure();
    test_reset_mid();
    test_layers("restart", 3'd1, 1, 16'h0605);
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
